// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: operation codes, FSM states and helpers shared by universal_shift_reg.
package shift_reg_pkg;
    typedef enum logic [2:0] {
        HOLD = 3'd0,
        LOAD = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        ROL  = 3'd4,
        ROR  = 3'd5,
        ASR  = 3'd6,
        RSVD = 3'd7
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    function automatic logic is_shift(input logic [2:0] mode);
        return !(mode == HOLD || mode == LOAD || mode == RSVD);
    endfunction
endpackage

// File: rtl/shift_reg_op.sv
// shift_reg_op: combinational next-value function shared by single-step and burst paths.
module shift_reg_op
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic             serial_in,
    output logic [WIDTH-1:0] result
);
    always_comb begin
        result = mode == LOAD ? data :
                 mode == SHL  ? {r[WIDTH-2:0], serial_in} :
                 mode == SHR  ? {serial_in, r[WIDTH-1:1]} :
                 mode == ROL  ? {r[WIDTH-2:0], r[WIDTH-1]} :
                 mode == ROR  ? {r[0], r[WIDTH-1:1]} :
                 mode == ASR  ? {r[WIDTH-1], r[WIDTH-1:1]} : r;
    end
endmodule

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit register with per-cycle ops and an N-step burst shift engine.
// Defining SHIFT_REG_PARITY_EN adds io_parity, the registered XOR of io_out.
module universal_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_enable,
    input  logic [2:0]       io_mode,
    input  logic [WIDTH-1:0] io_in,
    input  logic             io_serial_in,
    input  logic             io_start,
    input  logic [CNT_W-1:0] io_count,
    output logic [WIDTH-1:0] io_out,
    output logic             io_busy,
    output logic             io_done
`ifdef SHIFT_REG_PARITY_EN
    ,
    output logic             io_parity
`endif
);
    state_e           state, state_d;
    mode_e            mode_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, clamped;
    logic [WIDTH-1:0] reg_q, reg_d, op_result;
    logic [2:0]       op_mode;
    logic             done_q, done_d, go_burst, last;

    assign clamped  = io_count > CNT_W'(WIDTH) ? CNT_W'(WIDTH) : io_count;
    assign go_burst = io_start && clamped != '0 && is_shift(io_mode);
    assign last     = state == BURST && cnt_q == CNT_W'(1);
    assign op_mode  = state == BURST ? mode_q : io_mode;

    shift_reg_op #(.WIDTH(WIDTH)) u_op (
        .r         (reg_q),
        .mode      (op_mode),
        .data      (io_in),
        .serial_in (io_serial_in),
        .result    (op_result)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state == IDLE ? (go_burst ? BURST : IDLE) : (last ? IDLE : BURST);
    end

    // Accepting a start only latches the burst; the register is left alone on that edge.
    always_comb begin
        reg_d  = state == BURST ? op_result : (!io_start && io_enable) ? op_result : reg_q;
        cnt_d  = state == BURST ? cnt_q - CNT_W'(1) : io_start ? clamped : cnt_q;
        done_d = state == BURST ? last : io_start && !go_burst;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_q  <= RESET_VAL;
            mode_q <= HOLD;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            reg_q  <= reg_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            if (state == IDLE && io_start) mode_q <= mode_e'(io_mode);
        end
    end

`ifdef SHIFT_REG_PARITY_EN
    logic parity_q;
    always_ff @(posedge clk) begin
        if (reset) parity_q <= ^RESET_VAL;
        else       parity_q <= ^reg_d;
    end
    assign io_parity = parity_q;
`endif

    always_comb begin
        io_out  = reg_q;
        io_busy = state == BURST;
        io_done = done_q;
    end
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed self-checking bench for universal_shift_reg (WIDTH=8, RESET_VAL=A5).
module tb_universal_shift_reg;
    logic       clk = 1'b0;
    logic       reset, io_enable, io_serial_in, io_start;
    logic [2:0] io_mode;
    logic [7:0] io_in, io_out;
    logic [3:0] io_count;
    logic       io_busy, io_done;
`ifdef SHIFT_REG_PARITY_EN
    logic       io_parity;
`endif
    int total = 0, passed = 0;

    universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_enable    (io_enable),
        .io_mode      (io_mode),
        .io_in        (io_in),
        .io_serial_in (io_serial_in),
        .io_start     (io_start),
        .io_count     (io_count),
        .io_out       (io_out),
        .io_busy      (io_busy),
        .io_done      (io_done)
`ifdef SHIFT_REG_PARITY_EN
        ,
        .io_parity    (io_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic op(input logic [2:0] m, input logic [7:0] d, input logic s);
        io_enable = 1'b1; io_mode = m; io_in = d; io_serial_in = s;
        step();
        io_enable = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_burst [4];
        exp_burst = '{8'h78, 8'h3C, 8'h1E, 8'h0F};
        reset = 1'b1; io_enable = 1'b0; io_mode = 3'd0; io_in = '0;
        io_serial_in = 1'b0; io_start = 1'b0; io_count = '0;
        step();
        step();
        reset = 1'b0;
        check("reset_out", io_out, 8'hA5);
        check("reset_busy", {7'd0, io_busy}, 8'd0);
        check("reset_done", {7'd0, io_done}, 8'd0);
        repeat (5) step();
        check("idle_hold", io_out, 8'hA5);

        op(3'd1, 8'h81, 1'b0); check("load81", io_out, 8'h81);
        op(3'd2, 8'h00, 1'b1); check("shl", io_out, 8'h03);
        op(3'd5, 8'h00, 1'b0); check("ror", io_out, 8'h81);
        op(3'd6, 8'h00, 1'b0); check("asr", io_out, 8'hC0);
        op(3'd7, 8'hFF, 1'b1); check("rsvd", io_out, 8'hC0);
`ifdef SHIFT_REG_PARITY_EN
        op(3'd1, 8'h07, 1'b0); check("par_load07", {7'd0, io_parity}, 8'd1);
        op(3'd2, 8'h00, 1'b0); check("par_shl", {7'd0, io_parity}, 8'd1);
        op(3'd1, 8'h03, 1'b0); check("par_load03", {7'd0, io_parity}, 8'd0);
`endif

        // SHR burst of 4, then a back-to-back ROL burst of 2 started in the done cycle
        op(3'd1, 8'hF0, 1'b0);
        io_start = 1'b1; io_mode = 3'd3; io_count = 4'd4; io_serial_in = 1'b0;
        step();
        io_start = 1'b0; io_mode = 3'd1; io_count = 4'd0;
        check("b_accept_out", io_out, 8'hF0);
        check("b_accept_busy", {7'd0, io_busy}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("b_out%0d", i), io_out, exp_burst[i]);
            check($sformatf("b_busy%0d", i), {7'd0, io_busy}, {7'd0, i != 3});
            check($sformatf("b_done%0d", i), {7'd0, io_done}, {7'd0, i == 3});
        end
        io_start = 1'b1; io_mode = 3'd4; io_count = 4'd2;
        step();
        io_start = 1'b0;
        check("bb_accept_busy", {7'd0, io_busy}, 8'd1);
        check("bb_accept_done", {7'd0, io_done}, 8'd0);
        step(); check("bb_out0", io_out, 8'h1E);
        step(); check("bb_out1", io_out, 8'h3C);
        check("bb_done", {7'd0, io_done}, 8'd1);
        check("bb_busy", {7'd0, io_busy}, 8'd0);
        step(); check("bb_done_clear", {7'd0, io_done}, 8'd0);

        // count 0 and non-shift mode: immediate done, no register change
        io_start = 1'b1; io_mode = 3'd2; io_count = 4'd0;
        step();
        io_start = 1'b0;
        check("c0_out", io_out, 8'h3C);
        check("c0_busy", {7'd0, io_busy}, 8'd0);
        check("c0_done", {7'd0, io_done}, 8'd1);
        step(); check("c0_done_clear", {7'd0, io_done}, 8'd0);
        io_start = 1'b1; io_enable = 1'b1; io_mode = 3'd1; io_in = 8'hFF; io_count = 4'd3;
        step();
        io_start = 1'b0; io_enable = 1'b0;
        check("ns_out", io_out, 8'h3C);
        check("ns_busy", {7'd0, io_busy}, 8'd0);
        check("ns_done", {7'd0, io_done}, 8'd1);

        // count 15 clamps to 8: ROL of 5A comes back to 5A
        op(3'd1, 8'h5A, 1'b0);
        io_start = 1'b1; io_mode = 3'd4; io_count = 4'd15;
        step();
        io_start = 1'b0;
        repeat (7) step();
        check("clamp_7_out", io_out, 8'h2D);
        check("clamp_7_busy", {7'd0, io_busy}, 8'd1);
        step();
        check("clamp_out", io_out, 8'h5A);
        check("clamp_busy", {7'd0, io_busy}, 8'd0);
        check("clamp_done", {7'd0, io_done}, 8'd1);

        // reset during the second burst cycle aborts without a done pulse
        op(3'd1, 8'hF0, 1'b0);
        io_start = 1'b1; io_mode = 3'd3; io_count = 4'd4;
        step();
        io_start = 1'b0;
        step();
        check("abort_pre", io_out, 8'h78);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_out", io_out, 8'hA5);
        check("abort_busy", {7'd0, io_busy}, 8'd0);
        check("abort_done", {7'd0, io_done}, 8'd0);
        step();
        check("abort_done2", {7'd0, io_done}, 8'd0);
        check("abort_hold", io_out, 8'hA5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the fixed 8-bit enable register: a WIDTH-bit register with selectable per-cycle operations and an autonomous N-step burst shift engine.
- Operations: hold, parallel load, logical/arithmetic shift, rotate.
- Used as serializer/deserializer, barrel-free multi-step shifter and general enable-register in datapaths.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RESET_VAL, 0, register value after reset (WIDTH bits).
- CNT_W, $clog2(WIDTH+1), width of burst count (derived, not overridden).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- io_enable  input  1  perform io_mode operation this cycle (idle only).
- io_mode  input  3  0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 reserved (=HOLD).
- io_in  input  WIDTH  parallel load data.
- io_serial_in  input  1  fill bit for SHL (into LSB) / SHR (into MSB).
- io_start  input  1  begin burst using io_mode and io_count.
- io_count  input  CNT_W  burst shift count; values >WIDTH clamp to WIDTH.
- io_out  output  WIDTH  register contents.
- io_busy  output  1  burst in progress.
- io_done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (synchronous, has priority over everything): register=RESET_VAL, state IDLE, io_busy=0, io_done=0, latched mode/count cleared.
- Op semantics (r = register): SHL {r[W-2:0],serial_in}; SHR {serial_in,r[W-1:1]}; ROL {r[W-2:0],r[W-1]}; ROR {r[0],r[W-1:1]}; ASR {r[W-1],r[W-1:1]}; LOAD io_in; HOLD/7 unchanged.
- FSM states: IDLE, BURST.
- IDLE, io_start=1 (priority over io_enable): latch mode and clamped count, no register change this edge.
  - Count 0 or non-shift mode (0,1,7): stay IDLE; io_done=1 next cycle.
  - Otherwise: go BURST, io_busy=1 from next cycle.
- IDLE, io_start=0, io_enable=1: apply io_mode at this edge (1-cycle latency to io_out). io_done=0.
- IDLE, both 0: hold.
- BURST: one latched shift per edge, io_serial_in sampled live each edge.
  - Remaining count decrements per shift.
  - On edge performing last (Nth) shift: go IDLE, io_busy=0, io_done=1 for exactly the following cycle.
  - Start accepted at edge t0 -> shifts at t0+1..t0+N; io_busy high cycles t0+1..t0+N; io_done high cycle after edge t0+N.
  - io_start, io_enable, io_mode, io_count ignored while busy.
- io_start in cycle where io_done=1 is accepted normally (back-to-back bursts).
- Reset asserted mid-burst: burst aborted, no io_done pulse.
- io_out, io_busy, io_done are registered outputs (no combinational input->output paths).

Optional Feature:
- SHIFT_REG_PARITY_EN.
  - Defined: extra output io_parity (1 bit) = registered XOR-reduction of next register value, so io_parity always matches current io_out; reset value = ^RESET_VAL.
  - Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package shift_reg_pkg: mode enum (HOLD..ASR, RSVD), FSM state enum, op-code constants.
- Sub-module shift_reg_op: purely combinational next-value function (r, mode, io_in, serial_in -> next r), shared by single-step and burst paths.

Test Plan:
- Reset, RESET_VAL=8'hA5: after reset io_out=A5, busy=0, done=0; enable=0 for 5 cycles -> io_out stays A5.
- LOAD 8'h81, then SHL serial_in=1 -> 03; ROR -> 81; ASR -> C0; mode 7 -> C0 unchanged.
- Burst: LOAD 8'hF0, start SHR count=4 serial_in=0 -> io_out 78,3C,1E,0F on successive cycles, busy high 4 cycles, done pulses once after 0F.
- Boundaries:
  - start count=0 -> done next cycle, register unchanged, busy never set.
  - count=15 with WIDTH=8 clamps to 8 shifts -> ROL of 8'h5A returns 5A.
- Reset asserted on 2nd burst cycle -> io_out=RESET_VAL, busy=0, no done pulse.
- Back-to-back: start asserted in done cycle -> second burst runs.
- Parity build: load 8'h07 -> io_parity=1; SHL serial_in=0 -> io_parity stays 1.
- Parity build: load 8'h03 -> io_parity=0.
